// File: rtl/kernel_kcore_hls_deadlock_report_unit.sv
// Deadlock report collector: confirms a persistent dependence, launches the trace token from one
// origin process, follows it around the wait cycle and emits a single report.
module kernel_kcore_hls_deadlock_report_unit #(
    parameter int PROC_NUM       = 4,
    parameter int ID_W           = 2,
    parameter int PERSIST_CYCLES = 16,
    parameter int TRACE_TIMEOUT  = 256,
    parameter int CNT_W          = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PROC_NUM-1:0] dl_in_vec,
    output logic [PROC_NUM-1:0] origin,
    output logic                token_clear,
    output logic                dl_detect_out,
    output logic                report_valid,
    input  logic                report_ready,
    output logic [ID_W-1:0]     report_origin,
    output logic [PROC_NUM-1:0] report_chain,
    output logic                report_timeout,
    output logic [CNT_W-1:0]    report_cycles
);

    localparam int PCW = $clog2(PERSIST_CYCLES) + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ORIGIN = 3'd1,
        TRACE  = 3'd2,
        REPORT = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t              state_reg, state_next;
    logic [PCW-1:0]      persist_cnt_reg, persist_cnt_next;
    logic [ID_W-1:0]     origin_id_reg, origin_id_next;
    logic [PROC_NUM-1:0] origin_reg, origin_next;
    logic                dl_detect_reg, dl_detect_next;
    logic [PROC_NUM-1:0] chain_reg, chain_next;
    logic [CNT_W-1:0]    trace_cnt_reg, trace_cnt_next;
    logic                report_valid_reg, report_valid_next;
    logic [ID_W-1:0]     report_origin_reg, report_origin_next;
    logic [PROC_NUM-1:0] report_chain_reg, report_chain_next;
    logic                report_timeout_reg, report_timeout_next;
    logic [CNT_W-1:0]    report_cycles_reg, report_cycles_next;

    logic [PROC_NUM-1:0] first_hot;
    logic [ID_W-1:0]     lowest_id;
    logic                persist_hit;
    logic                token_returned;
    logic                trace_expired;

    // Lowest-index priority: a bit wins only when no lower-index bit is set.
    genvar gi;
    generate
        for (gi = 0; gi < PROC_NUM; gi++) begin : g_first_hot
            localparam logic [PROC_NUM-1:0] LOW_MASK = PROC_NUM'((64'd1 << gi) - 64'd1);
            assign first_hot[gi] = dl_in_vec[gi] & ~(|(dl_in_vec & LOW_MASK));
        end
    endgenerate

    always_comb begin
        lowest_id = '0;
        for (int i = 0; i < PROC_NUM; i++) begin
            if (first_hot[i]) lowest_id = ID_W'(i);
        end
    end

    assign persist_hit    = (|dl_in_vec) && (persist_cnt_reg == PCW'(PERSIST_CYCLES - 1));
    assign token_returned = (state_reg == TRACE) && dl_in_vec[origin_id_reg] && (trace_cnt_reg != '0);
    assign trace_expired  = (state_reg == TRACE) && (trace_cnt_reg == CNT_W'(TRACE_TIMEOUT - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg          <= IDLE;
            persist_cnt_reg    <= '0;
            origin_id_reg      <= '0;
            origin_reg         <= '0;
            dl_detect_reg      <= 1'b0;
            chain_reg          <= '0;
            trace_cnt_reg      <= '0;
            report_valid_reg   <= 1'b0;
            report_origin_reg  <= '0;
            report_chain_reg   <= '0;
            report_timeout_reg <= 1'b0;
            report_cycles_reg  <= '0;
        end else begin
            state_reg          <= state_next;
            persist_cnt_reg    <= persist_cnt_next;
            origin_id_reg      <= origin_id_next;
            origin_reg         <= origin_next;
            dl_detect_reg      <= dl_detect_next;
            chain_reg          <= chain_next;
            trace_cnt_reg      <= trace_cnt_next;
            report_valid_reg   <= report_valid_next;
            report_origin_reg  <= report_origin_next;
            report_chain_reg   <= report_chain_next;
            report_timeout_reg <= report_timeout_next;
            report_cycles_reg  <= report_cycles_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (persist_hit) state_next = ORIGIN;
            ORIGIN:  state_next = TRACE;
            TRACE:   if (token_returned || trace_expired) state_next = REPORT;
            REPORT:  if (report_ready) state_next = DONE;
            DONE:    state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        token_clear         = 1'b0;
        persist_cnt_next    = persist_cnt_reg;
        origin_id_next      = origin_id_reg;
        origin_next         = '0;
        dl_detect_next      = dl_detect_reg;
        chain_next          = chain_reg;
        trace_cnt_next      = trace_cnt_reg;
        report_valid_next   = report_valid_reg;
        report_origin_next  = report_origin_reg;
        report_chain_next   = report_chain_reg;
        report_timeout_next = report_timeout_reg;
        report_cycles_next  = report_cycles_reg;
        case (state_reg)
            IDLE: begin
                persist_cnt_next = (|dl_in_vec) ? persist_cnt_reg + PCW'(1) : '0;
                if (persist_hit) begin
                    origin_id_next   = lowest_id;
                    origin_next      = first_hot;
                    dl_detect_next   = 1'b1;
                    persist_cnt_next = '0;
                end
            end
            ORIGIN: begin
                chain_next     = origin_reg;
                trace_cnt_next = '0;
            end
            TRACE: begin
                chain_next     = chain_reg | dl_in_vec;
                trace_cnt_next = (&trace_cnt_reg) ? trace_cnt_reg : trace_cnt_reg + CNT_W'(1);
                // Clear must coincide with the unit's own detect so it can drop its token.
                token_clear    = token_returned || trace_expired;
                if (token_returned || trace_expired) begin
                    report_valid_next   = 1'b1;
                    report_origin_next  = origin_id_reg;
                    report_chain_next   = chain_reg | dl_in_vec;
                    report_timeout_next = !token_returned;
                    report_cycles_next  = trace_cnt_reg;
                end
            end
            REPORT: begin
                if (report_ready) report_valid_next = 1'b0;
            end
            default: ;
        endcase
    end

    assign origin         = origin_reg;
    assign dl_detect_out  = dl_detect_reg;
    assign report_valid   = report_valid_reg;
    assign report_origin  = report_origin_reg;
    assign report_chain   = report_chain_reg;
    assign report_timeout = report_timeout_reg;
    assign report_cycles  = report_cycles_reg;

endmodule

// File: tb/tb_kernel_kcore_hls_deadlock_report_unit.sv
// Randomized scenario bench: each scenario is reset, persistence build-up, trace and report,
// with expectations computed from the stimulus arrays.
module tb_kernel_kcore_hls_deadlock_report_unit;

    localparam int PROC_NUM = 4;
    localparam int ID_W     = 2;
    localparam int P        = 5;
    localparam int T        = 12;
    localparam int CNT_W    = 16;

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic [PROC_NUM-1:0] dl_in_vec = '0;
    logic                report_ready = 1'b0;
    logic [PROC_NUM-1:0] origin;
    logic                token_clear;
    logic                dl_detect_out;
    logic                report_valid;
    logic [ID_W-1:0]     report_origin;
    logic [PROC_NUM-1:0] report_chain;
    logic                report_timeout;
    logic [CNT_W-1:0]    report_cycles;

    int checks   = 0;
    int failures = 0;

    kernel_kcore_hls_deadlock_report_unit #(
        .PROC_NUM(PROC_NUM), .ID_W(ID_W), .PERSIST_CYCLES(P),
        .TRACE_TIMEOUT(T), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset(reset), .dl_in_vec(dl_in_vec), .origin(origin),
        .token_clear(token_clear), .dl_detect_out(dl_detect_out),
        .report_valid(report_valid), .report_ready(report_ready),
        .report_origin(report_origin), .report_chain(report_chain),
        .report_timeout(report_timeout), .report_cycles(report_cycles)
    );

    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string ph);
        check_value({ph, "_origin"}, 32'(origin), 0);
        check_value({ph, "_clear"}, 32'(token_clear), 0);
        check_value({ph, "_detect"}, 32'(dl_detect_out), 0);
        check_value({ph, "_valid"}, 32'(report_valid), 0);
        check_value({ph, "_rorigin"}, 32'(report_origin), 0);
        check_value({ph, "_rchain"}, 32'(report_chain), 0);
        check_value({ph, "_rtimeout"}, 32'(report_timeout), 0);
        check_value({ph, "_rcycles"}, 32'(report_cycles), 0);
    endtask

    task automatic check_report(input string ph, input int oid, input logic [3:0] chain,
                                input bit timed_out, input int cyc);
        check_value({ph, "_rorigin"}, 32'(report_origin), 32'(oid));
        check_value({ph, "_rchain"}, 32'(report_chain), 32'(chain));
        check_value({ph, "_rtimeout"}, 32'(report_timeout), 32'(timed_out));
        check_value({ph, "_rcycles"}, 32'(report_cycles), 32'(cyc));
    endtask

    // mode: 0 free random, 1 never returns, 2 returns on last allowed cycle, 3 single late return
    task automatic run_scenario(input int mode, input int rst_at);
        logic [3:0] iv[$];
        logic [3:0] tv[T];
        int n, k, run, oid, e, r, w;
        bit ret;
        logic [3:0] chain;

        reset = 1'b0; dl_in_vec = '0; report_ready = 1'b0;
        repeat (2) @(negedge clock);
        #1 check_all_zero("reset");
        reset = 1'b1;

        n = P + int'($urandom_range(0, 15));
        for (int i = 0; i < n; i++)
            iv.push_back(($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15)));
        for (int i = n - P; i < n; i++)
            if (iv[i] == 4'd0) iv[i] = 4'($urandom_range(1, 15));
        k = -1; run = 0;
        for (int i = 0; i < n; i++) begin
            run = (iv[i] != 4'd0) ? run + 1 : 0;
            if (run == P && k < 0) k = i;
        end
        oid = 0;
        for (int b = PROC_NUM - 1; b >= 0; b--) if (iv[k][b]) oid = b;

        for (int i = 0; i <= k; i++) begin
            @(negedge clock); dl_in_vec = iv[i]; #1;
            check_value("idle_origin", 32'(origin), 0);
            check_value("idle_detect", 32'(dl_detect_out), 0);
            check_value("idle_clear", 32'(token_clear), 0);
        end

        @(negedge clock); dl_in_vec = 4'($urandom_range(0, 15)); #1;
        check_value("origin_strobe", 32'(origin), 32'(1 << oid));
        check_value("origin_detect", 32'(dl_detect_out), 1);
        check_value("origin_clear", 32'(token_clear), 0);
        check_value("origin_valid", 32'(report_valid), 0);

        for (int i = 0; i < T; i++) tv[i] = 4'($urandom_range(0, 15));
        r = int'($urandom_range(1, T - 2));
        for (int i = 1; i < T; i++) begin
            if (mode == 1 || mode == 3 || (mode == 2 && i < T - 1)) tv[i][oid] = 1'b0;
            if (mode == 2 && i == T - 1) tv[i][oid] = 1'b1;
            if (mode == 3 && i == r) tv[i][oid] = 1'b1;
        end
        if (mode == 3) tv[0][oid] = 1'b1;

        e = T - 1; ret = 1'b0;
        for (int i = 1; i < T; i++) begin
            if (tv[i][oid]) begin
                e = i; ret = 1'b1;
                break;
            end
        end
        chain = 4'(1 << oid);
        for (int i = 0; i <= e; i++) chain = chain | tv[i];

        for (int i = 0; i <= e; i++) begin
            @(negedge clock); dl_in_vec = tv[i]; #1;
            check_value("trace_clear", 32'(token_clear), 32'(i == e));
            check_value("trace_detect", 32'(dl_detect_out), 1);
            check_value("trace_origin", 32'(origin), 0);
            check_value("trace_valid", 32'(report_valid), 0);
            if (i == rst_at) begin
                #2 reset = 1'b0;
                #1 check_all_zero("async_reset");
                $display("scenario mode=%0d oid=%0d reset_in_trace_at=%0d", mode, oid, i);
                return;
            end
        end

        w = int'($urandom_range(0, 5));
        for (int j = 0; j <= w; j++) begin
            @(negedge clock);
            dl_in_vec = 4'($urandom_range(0, 15));
            report_ready = (j == w);
            #1;
            check_value("report_valid", 32'(report_valid), 1);
            check_value("report_detect", 32'(dl_detect_out), 1);
            check_value("report_clear", 32'(token_clear), 0);
            check_report("report", oid, chain, !ret, e);
        end

        for (int j = 0; j < 4; j++) begin
            @(negedge clock);
            dl_in_vec = 4'($urandom_range(1, 15));
            report_ready = 1'($urandom_range(0, 1));
            #1;
            check_value("done_valid", 32'(report_valid), 0);
            check_value("done_origin", 32'(origin), 0);
            check_value("done_clear", 32'(token_clear), 0);
            check_value("done_detect", 32'(dl_detect_out), 1);
            check_report("done", oid, chain, !ret, e);
        end
        $display("scenario mode=%0d oid=%0d ret=%0d cycles=%0d chain=%h wait=%0d",
                 mode, oid, ret, e, chain, w);
    endtask

    initial begin
        for (int s = 0; s < 24; s++) run_scenario(s % 4, -1);
        run_scenario(1, int'($urandom_range(0, T - 3)));
        run_scenario(0, -1);
        run_scenario(1, 0);
        run_scenario(2, -1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
